// File: rtl/axi_rd_arb_n.sv
// axi_rd_arb_n: N-master to 1-slave AXI4 read arbiter, one burst in flight.
// Round-robin by default; define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer).
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   m_ar*  / m_arready    per-master AR channels (packed, master i at slice i)
//   m_rvalid / m_rready   per-master R handshake; m_r* payload is shared
//   s_ar*  / s_r*         slave-side AR and R channels
//   busy                  high while a transaction is owned (ADDR or DATA)
//   grant                 index of the current owner, valid while busy
module axi_rd_arb_n #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_MST-1:0]          m_arvalid,
    output logic [N_MST-1:0]          m_arready,
    input  logic [N_MST*ADDR_W-1:0]   m_araddr,
    input  logic [N_MST*ID_W-1:0]     m_arid,
    input  logic [N_MST*8-1:0]        m_arlen,
    input  logic [N_MST*3-1:0]        m_arsize,
    output logic [N_MST-1:0]          m_rvalid,
    input  logic [N_MST-1:0]          m_rready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [1:0]                m_rresp,
    output logic                      m_rlast,
    output logic [ID_W-1:0]           m_rid,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [ID_W-1:0]           s_arid,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic [ID_W-1:0]           s_rid,
    output logic                      busy,
    output logic [$clog2(N_MST)-1:0]  grant
);

    localparam int GW = $clog2(N_MST);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] winner;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last to write.
    always_comb begin
        winner = '0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (m_arvalid[i]) winner = GW'(i);
        end
    end
`else
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] sel;
    logic          found;

    // First requester at or above ptr, wrapping past N_MST-1 to 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel    = '0;
        for (int k = 0; k < N_MST; k++) begin
            sel = GW'((int'(ptr_q) + k) % N_MST);
            if (!found && m_arvalid[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|m_arvalid) begin
                    grant_d = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A master withdrawing its request releases the bus.
                if (m_arvalid[grant_q] && s_arready) state_d = DATA;
                else if (!m_arvalid[grant_q])        state_d = IDLE;
            end
            DATA: begin
                // Burst ends on RLAST only; ARLEN is never counted.
                if (s_rvalid && m_rready[grant_q] && s_rlast) begin
                    state_d = IDLE;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
                    ptr_d = (grant_q == GW'(N_MST - 1)) ? '0
                                                       : grant_q + GW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

    assign s_arvalid = (state_q == ADDR) && m_arvalid[grant_q];
    assign s_araddr  = m_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign s_arid    = m_arid[int'(grant_q)*ID_W +: ID_W];
    assign s_arlen   = m_arlen[int'(grant_q)*8 +: 8];
    assign s_arsize  = m_arsize[int'(grant_q)*3 +: 3];

    // Slave data outside DATA is left stalled rather than dropped.
    assign s_rready  = (state_q == DATA) && m_rready[grant_q];

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        if (state_q == ADDR) m_arready[grant_q] = s_arready;
        if (state_q == DATA) m_rvalid[grant_q]  = s_rvalid;
    end

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid;

endmodule

// File: tb/tb_axi_rd_arb_n.sv
// tb_axi_rd_arb_n: randomized scoreboard bench for axi_rd_arb_n (N_MST=4).
// Expected AR order and R beats come from a queue-based arbitration model.
module tb_axi_rd_arb_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0] m_araddr;
    logic [N*IW-1:0] m_arid;
    logic [N*8-1:0]  m_arlen;
    logic [N*3-1:0]  m_arsize;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [IW-1:0]   m_rid;
    logic            s_arvalid, s_arready;
    logic [AW-1:0]   s_araddr;
    logic [IW-1:0]   s_arid;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic            s_rvalid, s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [IW-1:0]   s_rid;
    logic            busy;
    logic [1:0]      grant;

    axi_rd_arb_n #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .busy(busy), .grant(grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string nm, input string det);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", nm, det);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a,
                                              input logic [7:0] b);
        return a ^ {b, b, b, b} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a,
                                             input logic [7:0] b);
        return a[1:0] ^ b[1:0];
    endfunction

    // Reference arbitration: first pending master from p upward, wrapping.
    int ptr_m = 0;

    function automatic int pick(input logic [N-1:0] pend, input int p);
        int base = p;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        base = 0;
`endif
        for (int k = 0; k < N; k++)
            if (pend[(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    logic [31:0] req_addr[N];
    logic [3:0]  req_id[N];
    logic [7:0]  req_len[N];
    logic [2:0]  req_size[N];

    task automatic predict(input logic [N-1:0] mask);
        logic [N-1:0] pend = mask;
        int w;
        ar_t a;
        r_t  r;
        while (pend != '0) begin
            w = pick(pend, ptr_m);
            a.m = w; a.addr = req_addr[w]; a.id = req_id[w];
            a.len = req_len[w]; a.size = req_size[w];
            exp_ar.push_back(a);
            for (int b = 0; b <= int'(req_len[w]); b++) begin
                r.m    = w;
                r.data = beat_data(req_addr[w], 8'(b));
                r.resp = beat_resp(req_addr[w], 8'(b));
                r.last = (b == int'(req_len[w]));
                r.id   = req_id[w];
                exp_r.push_back(r);
            end
            pend[w] = 1'b0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            ptr_m = (w + 1) % N;
`endif
        end
    endtask

    // Master and slave stimulus models.
    logic [N-1:0] pend_req = '0;
    bit           sl_act = 0;
    bit           sl_vld = 0;
    logic [31:0]  sl_addr;
    logic [7:0]   sl_len, sl_beat;
    logic [3:0]   sl_id;
    int           done_cnt = 0;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) m_arvalid[i] = pend_req[i];
        m_rready  = N'($urandom);
        s_arready = ($urandom_range(0, 3) != 0);
        if (sl_act) begin
            if (!sl_vld) sl_vld = ($urandom_range(0, 3) != 0);
            s_rvalid = sl_vld;
            s_rdata  = beat_data(sl_addr, sl_beat);
            s_rresp  = beat_resp(sl_addr, sl_beat);
            s_rlast  = (sl_beat == sl_len);
            s_rid    = sl_id;
        end else begin
            s_rvalid = ($urandom_range(0, 2) == 0);
            s_rdata  = $urandom;
            s_rresp  = 2'($urandom);
            s_rlast  = 1'($urandom);
            s_rid    = IW'($urandom);
        end
    endtask

    task automatic sample_handshakes();
        for (int i = 0; i < N; i++)
            if (m_arvalid[i] && m_arready[i]) pend_req[i] = 1'b0;
        if (sl_act && s_rvalid && s_rready) begin
            sl_vld = 0;
            if (sl_beat == sl_len) begin
                sl_act = 0;
                done_cnt++;
            end else begin
                sl_beat++;
            end
        end
        if (s_arvalid && s_arready) begin
            sl_act  = 1;
            sl_vld  = 0;
            sl_addr = s_araddr;
            sl_len  = s_arlen;
            sl_id   = s_arid;
            sl_beat = '0;
        end
    endtask

    task automatic run_round(input logic [N-1:0] mask, input int flen,
                             input bit stop_mid, output bit stopped);
        int cyc = 0;
        int target = $countones(mask);
        stopped = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_addr[i] = $urandom;
                req_id[i]   = 4'($urandom);
                req_len[i]  = (flen >= 0) ? 8'(flen) : 8'($urandom_range(0, 3));
                req_size[i] = 3'($urandom_range(0, 2));
                m_araddr[i*AW +: AW] = req_addr[i];
                m_arid[i*IW +: IW]   = req_id[i];
                m_arlen[i*8 +: 8]    = req_len[i];
                m_arsize[i*3 +: 3]   = req_size[i];
            end
        end
        predict(mask);
        done_cnt = 0;
        pend_req = mask;
        while (done_cnt < target && cyc < 2000 && !stopped) begin
            @(negedge clock);
            drive_inputs();
            #4;
            if (cyc == 0)
                chk(!s_arvalid && !busy, "idle_start",
                    $sformatf("s_arvalid=%0b busy=%0b want 0 0", s_arvalid, busy));
            if (cyc == 1)
                chk(s_arvalid, "ar_latency",
                    $sformatf("s_arvalid=%0b want 1", s_arvalid));
            sample_handshakes();
            cyc++;
            if (stop_mid && sl_act && sl_beat >= 8'd1) stopped = 1;
        end
        if (!stopped) begin
            chk(done_cnt == target, "round_done",
                $sformatf("bursts=%0d want %0d", done_cnt, target));
            for (int k = 0; k < 2; k++) begin
                @(negedge clock);
                drive_inputs();
                #4;
                sample_handshakes();
            end
            chk(exp_ar.size() == 0 && exp_r.size() == 0, "drain",
                $sformatf("left ar=%0d r=%0d want 0 0", exp_ar.size(), exp_r.size()));
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a handshake.
    bit mon_act = 0;
    int mon_w   = 0;

    always begin
        ar_t ea;
        r_t  er;
        logic [N-1:0] oh;
        @(negedge clock);
        #4;
        if (reset) begin
            mon_act = 0;
        end else begin
            if (mon_act) begin
                oh = s_rvalid ? (N'(1) << mon_w) : '0;
                chk(m_rvalid == oh && s_rready == m_rready[mon_w] &&
                    busy && int'(grant) == mon_w, "r_route",
                    $sformatf("m_rvalid=%b s_rready=%0b busy=%0b grant=%0d want %b %0b 1 %0d",
                              m_rvalid, s_rready, busy, grant, oh, m_rready[mon_w], mon_w));
                if (s_rvalid && s_rready) begin
                    if (exp_r.size() == 0) begin
                        chk(0, "r_unexpected", "beat with empty queue, want none");
                    end else begin
                        er = exp_r.pop_front();
                        chk(er.m == mon_w && m_rdata == er.data &&
                            m_rresp == er.resp && m_rlast == er.last &&
                            m_rid == er.id, "r_beat",
                            $sformatf("m=%0d d=%h r=%0d l=%0b id=%0d want m=%0d d=%h r=%0d l=%0b id=%0d",
                                      mon_w, m_rdata, m_rresp, m_rlast, m_rid,
                                      er.m, er.data, er.resp, er.last, er.id));
                    end
                    if (s_rlast) mon_act = 0;
                end
            end else if (s_rvalid) begin
                chk(!s_rready && m_rvalid == '0, "stray",
                    $sformatf("s_rready=%0b m_rvalid=%b want 0 0", s_rready, m_rvalid));
            end
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) begin
                    chk(0, "ar_unexpected", "AR with empty queue, want none");
                end else begin
                    ea = exp_ar.pop_front();
                    oh = N'(1) << ea.m;
                    chk(int'(grant) == ea.m && s_araddr == ea.addr &&
                        s_arid == ea.id && s_arlen == ea.len &&
                        s_arsize == ea.size && m_arready == oh, "ar",
                        $sformatf("g=%0d a=%h id=%0d len=%0d sz=%0d rdy=%b want g=%0d a=%h id=%0d len=%0d sz=%0d rdy=%b",
                                  grant, s_araddr, s_arid, s_arlen, s_arsize, m_arready,
                                  ea.m, ea.addr, ea.id, ea.len, ea.size, oh));
                    mon_w   = ea.m;
                    mon_act = 1;
                end
            end
        end
    end

    task automatic clear_inputs();
        m_arvalid = '0; m_rready = '0;
        m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    endtask

    initial begin
        bit st;
        clear_inputs();
        #1;
        chk(m_arready == '0 && m_rvalid == '0 && !s_arvalid && !s_rready &&
            !busy && grant == '0, "reset_init",
            $sformatf("arrdy=%b rvld=%b sarv=%0b srrdy=%0b busy=%0b grant=%0d want all 0",
                      m_arready, m_rvalid, s_arvalid, s_rready, busy, grant));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_round(4'b0001, 0, 0, st);
        for (int k = 0; k < 3; k++) run_round(4'b0011, -1, 0, st);
        run_round(4'b0100, -1, 0, st);
        run_round(4'b1010, -1, 0, st);
        for (int k = 0; k < 40; k++) run_round(N'($urandom_range(1, 15)), -1, 0, st);

        run_round(4'b0100, 1, 0, st);
        run_round(4'b0010, 3, 1, st);
        chk(st, "reset_setup", $sformatf("mid-burst reached=%0b want 1", st));
        @(negedge clock);
        m_arvalid = '1;
        m_rready  = '1;
        s_rvalid  = 1'b1;
        s_arready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk(m_arready == '0 && m_rvalid == '0 && !s_arvalid && !s_rready &&
            !busy && grant == '0, "reset_mid",
            $sformatf("arrdy=%b rvld=%b sarv=%0b srrdy=%0b busy=%0b grant=%0d want all 0",
                      m_arready, m_rvalid, s_arvalid, s_rready, busy, grant));
        exp_ar.delete();
        exp_r.delete();
        ptr_m = 0; pend_req = '0; sl_act = 0; sl_vld = 0; done_cnt = 0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_round(4'b1001, -1, 0, st);
        for (int k = 0; k < 15; k++) run_round(N'($urandom_range(1, 15)), -1, 0, st);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
